// File: rtl/barret_mulfold_4057.sv
// Sequential a*b front end for the q=4057 Barrett reducer: radix-2 shift-add multiply, then one fold below 2^23.
// Optional build macro MULFOLD_RANGE_CHK_EN adds operand range checking and drives out_err.
module barret_mulfold_4057 #(
    parameter int unsigned Q          = 4057,
    parameter int unsigned W          = 12,
    parameter int unsigned OUT_W      = 23,
    parameter int unsigned FOLD_SHIFT = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dout_a,
    output logic             out_err
);

    localparam int unsigned ACC_W = 2 * W;
    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [ACC_W-1:0] FOLD_K   = ACC_W'(Q << FOLD_SHIFT);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FOLD,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_d;
    logic               valid_d;
    logic               ready_d;
    logic [OUT_W-1:0]   fold_c;

`ifdef MULFOLD_RANGE_CHK_EN
    localparam logic [W-1:0] Q_W = W'(Q);
    logic err_q, err_d;
    logic out_err_d;
`endif

    // One conditional subtraction of a multiple of Q keeps the product congruent and below 2^OUT_W.
    assign fold_c = (acc_q >= FOLD_K) ? OUT_W'(acc_q - FOLD_K) : OUT_W'(acc_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dout_d  = dout_a;
        valid_d = out_valid;
        ready_d = in_ready;
`ifdef MULFOLD_RANGE_CHK_EN
        err_d     = err_q;
        out_err_d = out_err;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = MUL;
`ifdef MULFOLD_RANGE_CHK_EN
                    err_d   = (a >= Q_W) || (b >= Q_W);
`endif
                end
            end
            MUL: begin
                // LSB-first over b: one partial product per cycle.
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + (ACC_W'(a_q) << cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FOLD;
                end
            end
            FOLD: begin
                dout_d  = fold_c;
                valid_d = 1'b1;
                state_d = HOLD;
`ifdef MULFOLD_RANGE_CHK_EN
                if (err_q) begin
                    dout_d    = '0;
                    out_err_d = 1'b1;
                end
`endif
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
`ifdef MULFOLD_RANGE_CHK_EN
                    out_err_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            dout_a    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            dout_a    <= dout_d;
            out_valid <= valid_d;
            in_ready  <= ready_d;
        end
    end

`ifdef MULFOLD_RANGE_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            out_err <= 1'b0;
        end else begin
            err_q   <= err_d;
            out_err <= out_err_d;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule
